lif_neuron_array: RTL and testbench



---
 rtl/lif_neuron_array.sv | 98 +++++++++
 tb/tb_lif_neuron_array.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N parallel leaky integrate-and-fire neurons with shared threshold, leak and refractory period.
// Define LIF_SPIKE_COUNT_EN to add per-neuron 8-bit saturating spike counters with readback.
module lif_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int IN_W = 8,
    parameter int DATA_W = 16,
    parameter int REFRAC_W = 4,
    parameter int RESET_SUB = 0,
    localparam int SEL_W = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef LIF_SPIKE_COUNT_EN
    input  logic                      clr_cnt,
    output logic [7:0]                spike_count,
`endif
    input  logic                      step,
    input  logic [N_NEURONS*IN_W-1:0] current,
    input  logic [DATA_W-1:0]         threshold,
    input  logic [3:0]                beta_shift,
    input  logic [REFRAC_W-1:0]       refrac_len,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         state_out,
    output logic [N_NEURONS-1:0]      spike,
    output logic                      spike_any,
    output logic                      step_done
);
    logic [DATA_W-1:0]   st [N_NEURONS];
    logic [DATA_W-1:0]   st_nx [N_NEURONS];
    logic [REFRAC_W-1:0] rc [N_NEURONS];
    logic [REFRAC_W-1:0] rc_nx [N_NEURONS];
    logic [N_NEURONS-1:0] fire;
    logic [DATA_W-1:0]   sel_st;

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_n
        logic              hold;
        logic [DATA_W-1:0] decayed, nxt;
        logic [DATA_W:0]   sum;
        assign hold    = rc[i] != '0;
        assign decayed = st[i] - (st[i] >> beta_shift);
        // one extra bit catches the carry so the sum clamps instead of wrapping
        assign sum     = {1'b0, decayed} + {{(DATA_W+1-IN_W){1'b0}}, current[i*IN_W +: IN_W]};
        assign nxt     = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
        assign fire[i] = step && !hold && nxt >= threshold;
        assign st_nx[i] = !step ? st[i] : hold ? '0 :
                          fire[i] ? (RESET_SUB != 0 ? nxt - threshold : '0) : nxt;
        assign rc_nx[i] = !step ? rc[i] : hold ? rc[i] - 1'b1 : fire[i] ? refrac_len : rc[i];
    end

    always_comb begin
        sel_st = '0;
        for (int k = 0; k < N_NEURONS; k++)
            if (sel == SEL_W'(k)) sel_st = st_nx[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= '{default: '0};
            rc        <= '{default: '0};
            spike     <= '0;
            spike_any <= 1'b0;
            step_done <= 1'b0;
            state_out <= '0;
        end else begin
            st        <= st_nx;
            rc        <= rc_nx;
            spike     <= fire;
            spike_any <= |fire;
            step_done <= step;
            state_out <= sel_st;
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [7:0] cnt [N_NEURONS];
    logic [7:0] cnt_nx [N_NEURONS];
    logic [7:0] sel_cnt;

    // clear wins over a same-cycle spike
    always_comb begin
        sel_cnt = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            cnt_nx[k] = clr_cnt ? '0 : (fire[k] && cnt[k] != 8'hff) ? cnt[k] + 8'd1 : cnt[k];
            if (sel == SEL_W'(k)) sel_cnt = cnt_nx[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '{default: '0};
            spike_count <= '0;
        end else begin
            cnt         <= cnt_nx;
            spike_count <= sel_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: random and directed stimulus on two configurations against an integer neuron model.
module tb_lif_neuron_array;
    logic clk = 1'b0, rst_n = 1'b0, step = 1'b0;
    logic [3:0]  beta = '0;
    logic [31:0] cur0 = '0;
    logic [15:0] thr0 = '0;
    logic [3:0]  refrac0 = '0;
    logic [1:0]  sel0 = '0;
    logic [23:0] cur1 = '0;
    logic [7:0]  thr1 = 8'd255;
    logic [2:0]  refrac1 = '0;
    logic [1:0]  sel1 = '0;
    logic [15:0] so0;
    logic [3:0]  sp0;
    logic        any0, done0;
    logic [7:0]  so1;
    logic [2:0]  sp1;
    logic        any1, done1;
`ifdef LIF_SPIKE_COUNT_EN
    logic        clr = 1'b0;
    logic [7:0]  cnt0;
    int          mc0 [4];
    int          e_cnt0 = 0;
`endif

    int ms0 [4], mr0 [4], ms1 [3], mr1 [3];
    logic [3:0] e_sp0 = '0;
    logic [2:0] e_sp1 = '0;
    logic e_any0 = 0, e_done0 = 0, e_any1 = 0, e_done1 = 0;
    int e_so0 = 0, e_so1 = 0;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    lif_neuron_array #(.N_NEURONS(4), .IN_W(8), .DATA_W(16), .REFRAC_W(4), .RESET_SUB(0)) u0 (
        .clk(clk), .rst_n(rst_n),
`ifdef LIF_SPIKE_COUNT_EN
        .clr_cnt(clr), .spike_count(cnt0),
`endif
        .step(step), .current(cur0), .threshold(thr0), .beta_shift(beta),
        .refrac_len(refrac0), .sel(sel0), .state_out(so0), .spike(sp0),
        .spike_any(any0), .step_done(done0)
    );

    lif_neuron_array #(.N_NEURONS(3), .IN_W(8), .DATA_W(8), .REFRAC_W(3), .RESET_SUB(1)) u1 (
        .clk(clk), .rst_n(rst_n),
`ifdef LIF_SPIKE_COUNT_EN
        .clr_cnt(clr), .spike_count(),
`endif
        .step(step), .current(cur1), .threshold(thr1), .beta_shift(beta),
        .refrac_len(refrac1), .sel(sel1), .state_out(so1), .spike(sp1),
        .spike_any(any1), .step_done(done1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int integ(input int s, input int c, input int b, input int maxv);
        int d;
        d = s - (s >> b) + c;
        return d > maxv ? maxv : d;
    endfunction

    // Advance the model by the step about to be clocked in with the present inputs.
    task automatic model_update();
        int n;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin ms0[i] = 0; mr0[i] = 0; end
            for (int i = 0; i < 3; i++) begin ms1[i] = 0; mr1[i] = 0; end
            e_sp0 = '0; e_sp1 = '0; e_any0 = 0; e_any1 = 0; e_done0 = 0; e_done1 = 0;
            e_so0 = 0; e_so1 = 0;
`ifdef LIF_SPIKE_COUNT_EN
            for (int i = 0; i < 4; i++) mc0[i] = 0;
            e_cnt0 = 0;
`endif
            return;
        end
        e_sp0 = '0;
        e_sp1 = '0;
        if (step) begin
            for (int i = 0; i < 4; i++) begin
                if (mr0[i] > 0) begin
                    mr0[i]--;
                    ms0[i] = 0;
                end else begin
                    n = integ(ms0[i], int'((cur0 >> (8 * i)) & 32'hff), int'(beta), 65535);
                    if (n >= int'(thr0)) begin
                        e_sp0[i] = 1'b1;
                        mr0[i] = int'(refrac0);
                        ms0[i] = 0;
                    end else ms0[i] = n;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (mr1[i] > 0) begin
                    mr1[i]--;
                    ms1[i] = 0;
                end else begin
                    n = integ(ms1[i], int'((cur1 >> (8 * i)) & 24'hff), int'(beta), 255);
                    if (n >= int'(thr1)) begin
                        e_sp1[i] = 1'b1;
                        mr1[i] = int'(refrac1);
                        ms1[i] = n - int'(thr1);
                    end else ms1[i] = n;
                end
            end
        end
        e_any0 = |e_sp0; e_done0 = step; e_so0 = ms0[int'(sel0)];
        e_any1 = |e_sp1; e_done1 = step; e_so1 = int'(sel1) < 3 ? ms1[int'(sel1)] : 0;
`ifdef LIF_SPIKE_COUNT_EN
        for (int i = 0; i < 4; i++)
            if (clr) mc0[i] = 0;
            else if (e_sp0[i] && mc0[i] < 255) mc0[i]++;
        e_cnt0 = mc0[int'(sel0)];
`endif
    endtask

    task automatic cyc();
        model_update();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk("state_out0", int'(so0), e_so0);
        chk("spike0", int'(sp0), int'(e_sp0));
        chk("spike_any0", int'(any0), int'(e_any0));
        chk("step_done0", int'(done0), int'(e_done0));
        chk("state_out1", int'(so1), e_so1);
        chk("spike1", int'(sp1), int'(e_sp1));
        chk("spike_any1", int'(any1), int'(e_any1));
        chk("step_done1", int'(done1), int'(e_done1));
`ifdef LIF_SPIKE_COUNT_EN
        chk("spike_count0", int'(cnt0), e_cnt0);
`endif
    end

    initial begin
        repeat (2) cyc();
        chk("reset_state_out", int'(so0), 0);
        chk("reset_spike", int'(sp0), 0);
        rst_n = 1'b1;
        cyc();
        // integration with leak 1/4
        thr0 = 16'd1000; beta = 4'd2; cur0 = 32'd40; sel0 = 2'd0; step = 1'b1;
        cyc(); chk("integ1", int'(so0), 40);
        cyc(); chk("integ2", int'(so0), 70);
        cyc(); chk("integ3", int'(so0), 93);
        chk("integ_spike", int'(sp0), 0);
        chk("integ_done", int'(done0), 1);
        step = 1'b0;
        cyc(); chk("done_pulse", int'(done0), 0);
        chk("hold_state", int'(so0), 93);
        // asynchronous reset with nonzero states
        rst_n = 1'b0;
        #1; chk("async_clear", int'(so0), 0);
        cyc(); chk("rst_state_out", int'(so0), 0);
        chk("rst_done", int'(done0), 0);
        rst_n = 1'b1;
        cyc();
        cur0 = 32'd5; thr0 = 16'd100; step = 1'b1;
        cyc(); chk("first_step", int'(so0), 5);
        // fire and reset (clear on u0, subtract on u1)
        beta = 4'd15; cur0 = {8'd0, 8'd0, 8'd60, 8'd0}; sel0 = 2'd1;
        cur1 = {8'd0, 8'd60, 8'd0}; thr1 = 8'd100; sel1 = 2'd1;
        cyc(); chk("fire1", int'(so0), 60);
        chk("fire1_sub", int'(so1), 60);
        cyc(); chk("fire2_state", int'(so0), 0);
        chk("fire2_spike", int'(sp0), 2);
        chk("fire2_any", int'(any0), 1);
        chk("fire2_sub_state", int'(so1), 20);
        chk("fire2_sub_spike", int'(sp1), 2);
        // refractory on u0, saturation on u1
        cur0 = {8'd0, 8'd60, 8'd0, 8'd0}; refrac0 = 4'd2; sel0 = 2'd2;
        cur1 = {8'd0, 8'd0, 8'd200}; thr1 = 8'd255; sel1 = 2'd0;
        cyc(); chk("refr_int", int'(so0), 60);
        chk("sat1", int'(so1), 200);
        cyc(); chk("refr_fire", int'(sp0), 4);
        chk("refr_fire_state", int'(so0), 0);
        chk("sat2_spike", int'(sp1), 1);
        chk("sat2_state", int'(so1), 0);
        cyc(); chk("refr_k1_state", int'(so0), 0);
        chk("refr_k1_spike", int'(sp0), 0);
        cyc(); chk("refr_k2_state", int'(so0), 0);
        chk("refr_k2_spike", int'(sp0), 0);
        cyc(); chk("refr_resume", int'(so0), 60);
        step = 1'b0; sel1 = 2'd3;
        cyc(); chk("sel_out_of_range", int'(so1), 0);
`ifdef LIF_SPIKE_COUNT_EN
        thr0 = '0; refrac0 = '0; sel0 = 2'd0; step = 1'b1;
        repeat (300) cyc();
        chk("count_sat", int'(cnt0), 255);
        clr = 1'b1;
        cyc(); chk("count_clr", int'(cnt0), 0);
        clr = 1'b0; step = 1'b0;
`endif
        for (int c = 0; c < 3000; c++) begin
            step    = $urandom_range(0, 9) < 7;
            cur0    = $urandom;
            if ($urandom_range(0, 3) == 0) cur0 &= 32'h0f0f0f0f;
            cur1    = 24'($urandom);
            thr0    = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 600));
            thr1    = 8'($urandom);
            beta    = 4'($urandom);
            refrac0 = 4'($urandom_range(0, 3));
            refrac1 = 3'($urandom_range(0, 3));
            sel0    = 2'($urandom);
            sel1    = 2'($urandom);
`ifdef LIF_SPIKE_COUNT_EN
            clr     = $urandom_range(0, 49) == 0;
`endif
            rst_n   = $urandom_range(0, 499) != 0;
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
